alu_control_mdu: RTL and testbench



---
 rtl/alu_ctrl_pkg.sv | 54 +++++
 rtl/mdu_iter_core.sv | 99 +++++++++
 rtl/alu_control_mdu.sv | 115 +++++++++++
 tb/tb_alu_control_mdu.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU-control decoder and M-extension sequencer.
package alu_ctrl_pkg;

  localparam logic [3:0] CTL_AND  = 4'b0000;
  localparam logic [3:0] CTL_OR   = 4'b0001;
  localparam logic [3:0] CTL_ADD  = 4'b0010;
  localparam logic [3:0] CTL_XOR  = 4'b0011;
  localparam logic [3:0] CTL_SLL  = 4'b0100;
  localparam logic [3:0] CTL_SRL  = 4'b0101;
  localparam logic [3:0] CTL_SUB  = 4'b0110;
  localparam logic [3:0] CTL_SRA  = 4'b0111;
  localparam logic [3:0] CTL_SLT  = 4'b1000;
  localparam logic [3:0] CTL_SLTU = 4'b1001;
  localparam logic [3:0] CTL_MDU  = 4'b1111;

  localparam logic [1:0] ALU_LDST  = 2'b00;
  localparam logic [1:0] ALU_BR    = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;
  localparam logic [1:0] ALU_ITYPE = 2'b11;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } md_state_t;

  // Base integer funct3 map shared by R-type and I-type arithmetic.
  function automatic logic [3:0] base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  return CTL_ADD;
      3'b001:  return CTL_SLL;
      3'b010:  return CTL_SLT;
      3'b011:  return CTL_SLTU;
      3'b100:  return CTL_XOR;
      3'b101:  return CTL_SRL;
      3'b110:  return CTL_OR;
      default: return CTL_AND;
    endcase
  endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Iterative multiply/divide datapath: shift-add multiply, restoring divide, sign fixup.
// MDU_FAST_MUL_EN: multiplies are resolved combinationally on the start strobe.
module mdu_iter_core
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            step,
  input  logic            finish,
  input  logic [2:0]      fun3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] result
);

  logic [2:0]      f3_q;
  logic [XLEN-1:0] acc, q, m;
  logic            neg_q, neg_r, bzero;

  logic            a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0] abs_a, abs_b;
  logic [XLEN:0]   sum, shifted, diff;
  logic [XLEN-1:0] acc_n, q_n, quot, rem, div_res;

  function automatic logic [XLEN-1:0] fix_mul(input logic [2*XLEN-1:0] p, input logic neg,
                                               input logic [2:0] f3);
    logic [2*XLEN-1:0] s;
    s = neg ? -p : p;
    return (f3 == F3_MUL) ? s[XLEN-1:0] : s[2*XLEN-1:XLEN];
  endfunction

  always_comb begin
    a_sgn = !(fun3 inside {F3_MULHU, F3_DIVU, F3_REMU});
    b_sgn = !(fun3 inside {F3_MULHSU, F3_MULHU, F3_DIVU, F3_REMU});
    a_neg = a_sgn & op_a[XLEN-1];
    b_neg = b_sgn & op_b[XLEN-1];
    abs_a = a_neg ? -op_a : op_a;
    abs_b = b_neg ? -op_b : op_b;
  end

  // acc/q form {hi,lo} of the product while multiplying, {remainder,quotient} while dividing.
  always_comb begin
    sum     = {1'b0, acc} + {1'b0, (q[0] ? m : '0)};
    shifted = {acc, q[XLEN-1]};
    diff    = shifted - {1'b0, m};
    if (f3_q[2]) begin
      if (!diff[XLEN]) begin
        acc_n = diff[XLEN-1:0];
        q_n   = {q[XLEN-2:0], 1'b1};
      end else begin
        acc_n = shifted[XLEN-1:0];
        q_n   = {q[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_n = sum[XLEN:1];
      q_n   = {sum[0], q[XLEN-1:1]};
    end
    quot    = bzero ? '1 : (neg_q ? -q_n : q_n);
    rem     = neg_r ? -acc_n : acc_n;
    div_res = f3_q[1] ? rem : quot;
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_p;
  assign fast_p = (2*XLEN)'(abs_a) * (2*XLEN)'(abs_b);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f3_q   <= '0;
      acc    <= '0;
      q      <= '0;
      m      <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      bzero  <= 1'b0;
      result <= '0;
    end else if (start) begin
      f3_q  <= fun3;
      acc   <= '0;
      m     <= fun3[2] ? abs_b : abs_a;
      q     <= fun3[2] ? abs_a : abs_b;
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
      bzero <= (op_b == '0);
`ifdef MDU_FAST_MUL_EN
      if (!fun3[2]) result <= fix_mul(fast_p, a_neg ^ b_neg, fun3);
`endif
    end else if (step) begin
      acc <= acc_n;
      q   <= q_n;
      if (finish) result <= f3_q[2] ? div_res : fix_mul({acc_n, q_n}, neg_q, f3_q);
    end
  end

endmodule

// File: rtl/alu_control_mdu.sv
// Execute-stage ALU control decode plus M-extension sequencer with pipeline stall.
// MDU_FAST_MUL_EN: multiplies complete in one cycle; divides stay iterative.
module alu_control_mdu
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic            flush,
  input  logic [1:0]      ALUOp,
  input  logic [6:0]      fun7,
  input  logic [2:0]      fun3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic [3:0]      Control_out,
  output logic            md_busy,
  output logic            md_done,
  output logic [XLEN-1:0] md_result,
  output logic            stall
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;

  md_state_t        state, state_n;
  logic [CNT_W-1:0] cnt;
  logic             mreq, start, step, finish;

  always_comb begin
    Control_out = CTL_AND;
    case (ALUOp)
      ALU_LDST: Control_out = CTL_ADD;
      ALU_BR:   Control_out = CTL_SUB;
      ALU_RTYPE: begin
        if (fun7 == F7_BASE)
          Control_out = base_op(fun3);
        else if (fun7 == F7_ALT && fun3 == 3'b000)
          Control_out = CTL_SUB;
        else if (fun7 == F7_ALT && fun3 == 3'b101)
          Control_out = CTL_SRA;
        else if (fun7 == F7_MULDIV)
          Control_out = CTL_MDU;
      end
      default: begin
        Control_out = base_op(fun3);
        if (fun3 == 3'b101 && fun7[5]) Control_out = CTL_SRA;
      end
    endcase
  end

  assign mreq    = valid_in & (ALUOp == ALU_RTYPE) & (fun7 == F7_MULDIV);
  assign stall   = mreq & ~md_done;
  assign md_busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      if (start)     cnt <= CNT_W'(XLEN);
      else if (step) cnt <= cnt - CNT_W'(1);
    end
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    md_done = 1'b0;
    case (state)
      S_IDLE: begin
        if (mreq && !flush) begin
          start = 1'b1;
`ifdef MDU_FAST_MUL_EN
          state_n = fun3[2] ? S_BUSY : S_DONE;
`else
          state_n = S_BUSY;
`endif
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_n = S_IDLE;
        end else begin
          step = 1'b1;
          if (cnt == CNT_W'(1)) begin
            finish  = 1'b1;
            state_n = S_DONE;
          end
        end
      end
      S_DONE: begin
        md_done = !flush;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  mdu_iter_core #(.XLEN(XLEN)) u_core (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .step   (step),
    .finish (finish),
    .fun3   (fun3),
    .op_a   (op_a),
    .op_b   (op_b),
    .result (md_result)
  );

endmodule

// File: tb/tb_alu_control_mdu.sv
// Scoreboard bench for alu_control_mdu (XLEN=32): decode table, M ops, flush and reset aborts.
module tb_alu_control_mdu;

`ifdef MDU_FAST_MUL_EN
  localparam int unsigned MUL_LAT = 1;
`else
  localparam int unsigned MUL_LAT = 33;
`endif
  localparam int unsigned DIV_LAT = 33;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        valid_in = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  ALUOp = '0;
  logic [6:0]  fun7 = '0;
  logic [2:0]  fun3 = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [3:0]  Control_out;
  logic        md_busy, md_done, stall;
  logic [31:0] md_result;

  int unsigned vectors = 0;
  int unsigned miss = 0;
  int unsigned cyc = 0;
  logic [31:0] last_res = '0;

  logic [31:0] exp_res[$];
  int unsigned exp_at[$];
  string       exp_name[$];

  alu_control_mdu #(.XLEN(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .valid_in    (valid_in),
    .flush       (flush),
    .ALUOp       (ALUOp),
    .fun7        (fun7),
    .fun3        (fun3),
    .op_a        (op_a),
    .op_b        (op_b),
    .Control_out (Control_out),
    .md_busy     (md_busy),
    .md_done     (md_done),
    .md_result   (md_result),
    .stall       (stall)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miss++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Monitor: every md_done pulse is matched against the oldest expectation.
  always @(negedge clk) begin
    if (md_done) begin
      if (exp_res.size() == 0) begin
        vectors++;
        miss++;
        $display("FAIL unexpected_done got=%0h exp=none", md_result);
      end else begin
        string       nm;
        logic [31:0] r;
        int unsigned at;
        nm = exp_name.pop_front();
        r  = exp_res.pop_front();
        at = exp_at.pop_front();
        chk({nm, "_result"}, md_result, r);
        chk({nm, "_latency"}, cyc, at);
      end
    end
  end

  task automatic do_mop(input string nm, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input bit scr);
    int unsigned lat, t0, scnt;
    bit seen;
    lat = f3[2] ? DIV_LAT : MUL_LAT;
    @(posedge clk); #2;
    valid_in = 1'b1; ALUOp = 2'b10; fun7 = 7'b0000001; fun3 = f3; op_a = a; op_b = b; flush = 1'b0;
    t0 = cyc;
    exp_name.push_back(nm); exp_res.push_back(exp); exp_at.push_back(t0 + lat);
    last_res = exp;
    scnt = 0; seen = 1'b0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (md_done) begin
        seen = 1'b1;
        chk({nm, "_stall_at_done"}, stall, 0);
      end else begin
        if (stall) scnt++;
        // Operands and fun3 moved mid-op must not affect the result.
        if (scr && n == 3) begin op_a = ~a; op_b = 32'h3; fun3 = f3 ^ 3'b001; end
      end
    end
    if (!seen) begin
      vectors++; miss++;
      $display("FAIL %s_timeout got=no_done exp=done_at_%0d", nm, t0 + lat);
      void'(exp_name.pop_back()); void'(exp_res.pop_back()); void'(exp_at.pop_back());
    end else begin
      chk({nm, "_stall_cycles"}, scnt, lat);
    end
  endtask

  task automatic start_only(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #2;
    valid_in = 1'b1; ALUOp = 2'b10; fun7 = 7'b0000001; fun3 = f3; op_a = a; op_b = b;
  endtask

  // {ALUOp, fun7, fun3, expected Control_out}
  localparam logic [15:0] DEC [16] = '{
    {2'b10, 7'b0100000, 3'b000, 4'b0110}, {2'b10, 7'b0100000, 3'b101, 4'b0111},
    {2'b11, 7'b0100000, 3'b000, 4'b0010}, {2'b00, 7'b1111111, 3'b111, 4'b0010},
    {2'b01, 7'b0000001, 3'b010, 4'b0110}, {2'b10, 7'b0000000, 3'b000, 4'b0010},
    {2'b10, 7'b0000000, 3'b001, 4'b0100}, {2'b10, 7'b0000000, 3'b011, 4'b1001},
    {2'b10, 7'b0000000, 3'b110, 4'b0001}, {2'b10, 7'b0100000, 3'b001, 4'b0000},
    {2'b10, 7'b1000000, 3'b000, 4'b0000}, {2'b11, 7'b0100000, 3'b101, 4'b0111},
    {2'b11, 7'b0000000, 3'b101, 4'b0101}, {2'b11, 7'b1111111, 3'b010, 4'b1000},
    {2'b10, 7'b0000000, 3'b100, 4'b0011}, {2'b10, 7'b0000000, 3'b101, 4'b0101}
  };

  initial begin
    logic [15:0] v;
    #1 reset = 1'b1;
    #1;
    chk("rst_busy", md_busy, 0);
    chk("rst_done", md_done, 0);
    chk("rst_result", md_result, 0);
    chk("rst_stall", stall, 0);
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      v = DEC[i];
      @(posedge clk); #2;
      valid_in = 1'b1; ALUOp = v[15:14]; fun7 = v[13:7]; fun3 = v[6:4];
      #1;
      chk($sformatf("dec%0d_ctl", i), Control_out, v[3:0]);
      chk($sformatf("dec%0d_stall", i), stall, 0);
    end
    @(posedge clk); #2;
    valid_in = 1'b0; ALUOp = 2'b10; fun7 = 7'b0000001; fun3 = 3'b110;
    #1;
    chk("dec_mdu_ctl", Control_out, 4'b1111);
    chk("dec_mdu_stall_novalid", stall, 0);
    @(posedge clk); #2;
    chk("dec_mdu_no_start", md_busy, 0);

    do_mop("mul_7_m3",     3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b1);
    do_mop("mulhu_max",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0);
    do_mop("mulh_m1_m1",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0);
    do_mop("mulhsu_m1",    3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    do_mop("mul_6_7",      3'b000, 32'd6,        32'd7,        32'd42,       1'b0);
    do_mop("div_ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0);
    do_mop("rem_ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0);
    do_mop("divu_by0",     3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b0);
    do_mop("remu_by0",     3'b111, 32'd5,        32'd0,        32'd5,        1'b0);
    do_mop("div_m7_2",     3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b1);
    do_mop("rem_m7_2",     3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0);
    do_mop("div_m7_by0",   3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1'b0);
    do_mop("rem_m7_by0",   3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1'b0);
    do_mop("divu_42_6",    3'b101, 32'd42,       32'd6,        32'd7,        1'b0);
    do_mop("divu_max_2",   3'b101, 32'hFFFFFFFF, 32'd2,        32'h7FFFFFFF, 1'b0);
    do_mop("remu_max_10",  3'b111, 32'hFFFFFFFF, 32'd10,       32'd5,        1'b0);
    @(posedge clk); #2 valid_in = 1'b0;
    #1 chk("hold_after_done", md_result, last_res);

    // Flush wins over a new request in IDLE.
    @(posedge clk); #2;
    valid_in = 1'b1; ALUOp = 2'b10; fun7 = 7'b0000001; fun3 = 3'b100; flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0; valid_in = 1'b0;
    #1 chk("flush_idle_no_start", md_busy, 0);

    start_only(3'b100, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #2 flush = 1'b1;
    #1 chk("flush_busy_before", md_busy, 1);
    @(posedge clk); #2;
    flush = 1'b0; valid_in = 1'b0;
    #1;
    chk("flush_busy_idle", md_busy, 0);
    chk("flush_busy_stall", stall, 0);
    chk("flush_busy_result", md_result, last_res);
    repeat (40) @(posedge clk);
    #1 chk("flush_result_kept", md_result, last_res);

    start_only(3'b101, 32'd1000, 32'd3);
    repeat (10) @(posedge clk);
    #2 reset = 1'b1; valid_in = 1'b0;
    #1;
    chk("rst_mid_busy", md_busy, 0);
    chk("rst_mid_result", md_result, 0);
    chk("rst_mid_done", md_done, 0);
    @(posedge clk); #2 reset = 1'b0;

    do_mop("post_rst_div", 3'b100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0);
    @(posedge clk); #2 valid_in = 1'b0;
    repeat (5) @(posedge clk);
    chk("queue_drained", exp_res.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

endmodule
